// File: rtl/aes_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module   : aes_mode_controller
//  Purpose  : CBC/CTR sequencing controller in front of a fixed-latency
//             pipelined AES-256 datapath, with key-settle wait and output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_mode_controller #(
    parameter int CORE_LATENCY = 15,
    parameter int KEY_LATENCY  = 15,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         cfg_start,
    input  logic         cfg_mode,
    input  logic [127:0] iv,
    output logic         busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_key_w = (KEY_LATENCY > 0) ? $clog2(KEY_LATENCY + 1) : 1;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_key_wait = 2'd1;
    localparam logic [1:0] c_st_run      = 2'd2;
    localparam logic [1:0] c_st_drain    = 2'd3;

    logic [1:0]              r_state;
    logic                    r_mode;
    logic [c_key_w-1:0]      r_wait_cnt;
    logic [127:0]            r_chain;
    logic [127:0]            r_ctr;
    logic [127:0]            r_core_in;

    logic [CORE_LATENCY-1:0] r_tag_vld;
    logic [CORE_LATENCY-1:0] r_tag_last;
    logic [c_cnt_w-1:0]      r_in_flight;

    logic [127:0]            r_side_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_side_wr;
    logic [c_ptr_w-1:0]      r_side_rd;

    logic [128:0]            r_out_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_out_wr;
    logic [c_ptr_w-1:0]      r_out_rd;
    logic [c_cnt_w-1:0]      r_out_cnt;

    logic [c_cnt_w:0]        w_credit_used;
    logic                    w_credit_ok;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_capture_last;
    logic [127:0]            w_result;
    logic                    w_out_valid;
    logic                    w_pop;

    // Every accepted block holds a slot in either the pipeline or the output
    // FIFO until it is popped, so this sum bounds output FIFO occupancy.
    assign w_credit_used  = {1'b0, r_in_flight} + {1'b0, r_out_cnt};
    assign w_credit_ok    = (w_credit_used < (c_cnt_w + 1)'(FIFO_DEPTH));
    assign w_in_ready     = (r_state == c_st_run) && w_credit_ok &&
                            (r_mode || (r_in_flight == '0));
    assign w_accept       = in_valid && w_in_ready;
    assign w_capture      = r_tag_vld[CORE_LATENCY-1];
    assign w_capture_last = r_tag_last[CORE_LATENCY-1];
    assign w_result       = r_mode ? (core_out ^ r_side_mem[r_side_rd]) : core_out;
    assign w_out_valid    = (r_out_cnt != '0);
    assign w_pop          = w_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign core_in   = r_core_in;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_out_mem[r_out_rd][127:0] : 128'd0;
    assign out_last  = w_out_valid ? r_out_mem[r_out_rd][128] : 1'b0;
    assign busy      = (r_state != c_st_idle) || w_out_valid;

    // Session FSM, chaining registers and datapath input register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= c_st_idle;
            r_mode     <= 1'b0;
            r_wait_cnt <= '0;
            r_chain    <= '0;
            r_ctr      <= '0;
            r_core_in  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cfg_start) begin
                        r_mode     <= cfg_mode;
                        r_wait_cnt <= c_key_w'(KEY_LATENCY);
                        r_state    <= c_st_key_wait;
                        if (cfg_mode) begin
                            r_ctr <= iv;
                        end else begin
                            r_chain <= iv;
                        end
                    end
                end
                c_st_key_wait: begin
                    if (r_wait_cnt <= c_key_w'(1)) begin
                        r_wait_cnt <= '0;
                        r_state    <= c_st_run;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - c_key_w'(1);
                    end
                end
                c_st_run: begin
                    if (w_accept && in_last) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (r_in_flight == '0) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_accept) begin
                if (r_mode) begin
                    r_core_in <= r_ctr;
                    r_ctr     <= r_ctr + 128'd1;
                end else begin
                    r_core_in <= in_data ^ r_chain;
                end
            end

            // CBC accepts only with nothing in flight, so this never races an accept
            if (w_capture && !r_mode) begin
                r_chain <= core_out;
            end
        end
    end

    // Tag pipeline tracking which datapath slots carry live blocks
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tag_vld   <= '0;
            r_tag_last  <= '0;
            r_in_flight <= '0;
        end else begin
            for (int i = CORE_LATENCY - 1; i > 0; i--) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
            r_tag_vld[0]  <= w_accept;
            r_tag_last[0] <= w_accept && in_last;

            case ({w_accept, w_capture})
                2'b10:   r_in_flight <= r_in_flight + c_cnt_w'(1);
                2'b01:   r_in_flight <= r_in_flight - c_cnt_w'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Plaintext side FIFO pointers (CTR only); occupancy equals in_flight
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_side_wr <= '0;
            r_side_rd <= '0;
        end else begin
            if (w_accept && r_mode) begin
                r_side_wr <= r_side_wr + c_ptr_w'(1);
            end
            if (w_capture && r_mode) begin
                r_side_rd <= r_side_rd + c_ptr_w'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_accept && r_mode) begin
            r_side_mem[r_side_wr] <= in_data;
        end
    end

    // Output FIFO, first-word fall-through
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_out_wr <= r_out_wr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_out_rd <= r_out_rd + c_ptr_w'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_out_cnt <= r_out_cnt + c_cnt_w'(1);
                2'b01:   r_out_cnt <= r_out_cnt - c_cnt_w'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_capture) begin
            r_out_mem[r_out_wr] <= {w_capture_last, w_result};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_mode_controller
//  Purpose  : Self-checking bench with a behavioural fixed-latency core model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_mode_controller;

    localparam int CORE_LATENCY = 15;
    localparam int KEY_LATENCY  = 15;
    localparam int FIFO_DEPTH   = 16;

    localparam logic [127:0] c_pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] c_cp  = 128'h8eb395f9153223c86265e32b87948e76;
    localparam logic [127:0] c_cpo = 128'h714c6a06eacddc379d9a1cd4786b7189;
    localparam logic [127:0] c_bp_iv = 128'h100;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         cfg_start;
    logic         cfg_mode;
    logic [127:0] iv;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [127:0] core_in;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    aes_mode_controller #(
        .CORE_LATENCY (CORE_LATENCY),
        .KEY_LATENCY  (KEY_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_start (cfg_start),
        .cfg_mode  (cfg_mode),
        .iv        (iv),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .core_in   (core_in),
        .core_out  (core_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 sys_clk = ~sys_clk;

    // Stand-in cipher: the FIPS-197 AES-256 vector for the test plaintext, bitwise NOT otherwise
    function automatic logic [127:0] core_fn(input logic [127:0] x);
        return (x == c_pt) ? c_ct : ~x;
    endfunction

    logic [127:0] pipe [0:CORE_LATENCY-2];
    always @(posedge sys_clk) begin
        pipe[0] <= core_fn(core_in);
        for (int i = 1; i < CORE_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[CORE_LATENCY-2];

    typedef struct {
        logic         mode;
        logic [127:0] ivv;
        logic [127:0] data;
        logic [127:0] exp_core;
        logic [127:0] exp_out;
    } vec_t;
    vec_t tbl [5];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic start_session(input logic mode, input logic [127:0] ivv);
        cfg_mode  = mode;
        iv        = ivv;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
    endtask

    task automatic pop_expect(input string name, input logic [127:0] d, input logic l);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin tick(); n++; end
        chk({name, " valid"}, out_valid, 1);
        chk({name, " data"}, out_data, d);
        chk({name, " last"}, out_last, l);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_single(input int idx);
        int n;
        string nm;
        nm = $sformatf("vec%0d", idx);
        start_session(tbl[idx].mode, tbl[idx].ivv);
        chk({nm, " busy_start"}, busy, 1);
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        chk({nm, " key_wait"}, n, KEY_LATENCY);
        in_valid = 1'b1; in_data = tbl[idx].data; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        chk({nm, " core_in"}, core_in, tbl[idx].exp_core);
        chk({nm, " ready_drain"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk({nm, " latency"}, n, CORE_LATENCY);
        chk({nm, " out_data"}, out_data, tbl[idx].exp_out);
        chk({nm, " out_last"}, out_last, 1);
        chk({nm, " busy_hold"}, busy, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " out_valid_pop"}, out_valid, 0);
        chk({nm, " busy_end"}, busy, 0);
    endtask

    function automatic logic [127:0] bp_pt(input int i);
        return {32'ha5a50000 | 32'(i), 32'h0, 32'h12345678, 32'(i * 7)};
    endfunction

    function automatic logic [127:0] bp_exp(input int i);
        return ~(c_bp_iv + 128'(i)) ^ bp_pt(i);
    endfunction

    initial begin
        int n;
        int acc_cnt;
        int k;
        logic a;
        logic p;
        logic seen;

        tbl[0] = '{1'b0, 128'h0, c_pt, c_pt, c_ct};
        tbl[1] = '{1'b1, c_pt, 128'h0, c_pt, c_ct};
        tbl[2] = '{1'b0, c_pt, c_pt, 128'h0, {128{1'b1}}};
        tbl[3] = '{1'b1, 128'h0, c_pt, 128'h0, 128'hffeeddccbbaa99887766554433221100};
        tbl[4] = '{1'b0, {128{1'b1}}, c_pt, 128'hffeeddccbbaa99887766554433221100, c_pt};

        sys_rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; iv = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst busy", busy, 0);
        chk("rst core_in", core_in, 0);
        chk("rst out_data", out_data, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_single(i);

        // CBC two blocks: second accept waits for the first result to chain
        start_session(1'b0, 128'h0);
        wait_ready();
        in_valid = 1'b1; in_data = c_pt; in_last = 1'b0;
        tick();
        chk("cbc2 core_in0", core_in, c_pt);
        in_last = 1'b1;
        n = 0;
        do begin
            a = in_ready;
            tick();
            n++;
        end while (!a && n < 100);
        in_valid = 1'b0; in_last = 1'b0;
        chk("cbc2 accept_gap", n, CORE_LATENCY + 1);
        chk("cbc2 core_in1", core_in, c_cp);
        pop_expect("cbc2 out0", c_ct, 1'b0);
        pop_expect("cbc2 out1", c_cpo, 1'b1);
        wait_idle();

        // CTR counter wrap at all-ones
        start_session(1'b1, {128{1'b1}});
        wait_ready();
        in_valid = 1'b1; in_data = '0; in_last = 1'b0;
        tick();
        chk("wrap core_in0", core_in, {128{1'b1}});
        chk("wrap ready0", in_ready, 1);
        tick();
        chk("wrap core_in1", core_in, 128'h0);
        chk("wrap ready1", in_ready, 1);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("wrap core_in2", core_in, 128'h1);
        pop_expect("wrap out0", 128'h0, 1'b0);
        pop_expect("wrap out1", {128{1'b1}}, 1'b0);
        pop_expect("wrap out2", ~128'h1, 1'b1);
        wait_idle();

        // Backpressure: output stalled while 20 blocks are offered
        start_session(1'b1, c_bp_iv);
        acc_cnt = 0;
        k = 0;
        for (int cyc = 0; cyc < 300 && k < 20; cyc++) begin
            out_ready = (cyc >= 40);
            in_valid  = (acc_cnt < 20);
            in_data   = bp_pt(acc_cnt);
            in_last   = (acc_cnt == 19);
            if (cyc == 39) begin
                chk("bp accepted", acc_cnt, FIFO_DEPTH);
                chk("bp ready_low", in_ready, 0);
                chk("bp head_valid", out_valid, 1);
                chk("bp head_held", out_data, bp_exp(0));
            end
            a = in_valid && in_ready;
            p = out_valid && out_ready;
            if (p) begin
                chk($sformatf("bp out%0d data", k), out_data, bp_exp(k));
                chk($sformatf("bp out%0d last", k), out_last, (k == 19));
                k++;
            end
            tick();
            if (a) acc_cnt++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        chk("bp delivered", k, 20);
        wait_idle();
        chk("bp idle", busy, 0);

        // Start pulse in RUN must not disturb mode or counter
        start_session(1'b1, 128'h5000);
        wait_ready();
        in_valid = 1'b1; in_data = '0; in_last = 1'b0;
        tick();
        chk("ign core_in0", core_in, 128'h5000);
        tick();
        chk("ign core_in1", core_in, 128'h5001);
        in_valid = 1'b0;
        cfg_mode = 1'b0; iv = 128'hdead_beef; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("ign ready", in_ready, 1);
        in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("ign core_in2", core_in, 128'h5002);
        pop_expect("ign out0", ~128'h5000, 1'b0);
        pop_expect("ign out1", ~128'h5001, 1'b0);
        pop_expect("ign out2", ~128'h5002, 1'b1);
        wait_idle();

        // Reset with five blocks in flight
        start_session(1'b1, 128'h7000);
        wait_ready();
        in_valid = 1'b1; in_data = '0; in_last = 1'b0;
        repeat (5) tick();
        in_valid = 1'b0;
        tick();
        sys_rst = 1'b1;
        #2;
        chk("mrst in_ready", in_ready, 0);
        chk("mrst out_valid", out_valid, 0);
        chk("mrst out_last", out_last, 0);
        chk("mrst busy", busy, 0);
        chk("mrst core_in", core_in, 0);
        chk("mrst out_data", out_data, 0);
        tick();
        tick();
        sys_rst = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid || busy || in_ready) seen = 1'b1;
            tick();
        end
        chk("mrst quiet", seen, 0);
        run_single(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
